seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan.sv | 145 ++++++++++++++
 tb/tb_seg_scan.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// Multiplexed 7-segment scanner with PWM brightness and frame-synchronous double buffering.
// Optional lamp test input is enabled by defining SEG_SCAN_LAMPTEST_EN.
module seg_scan #(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 2,
  parameter int BRIGHT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*NDIG-1:0]     value,
  input  logic [NDIG-1:0]       dp,
  input  logic                  load,
  input  logic [BRIGHT_W-1:0]   bright,
  input  logic                  blank_lz,
`ifdef SEG_SCAN_LAMPTEST_EN
  input  logic                  lamp_test,
`endif
  output logic [7:0]            leds,
  output logic [NDIG-1:0]       ct,
  output logic                  frame_done
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [DW-1:0]       div;
  logic [BRIGHT_W-1:0] step;
  logic [IW-1:0]       idx;

  logic [4*NDIG-1:0]   stage_val;
  logic [NDIG-1:0]     stage_dp;
  logic                pend;
  logic [4*NDIG-1:0]   disp_val;
  logic [NDIG-1:0]     disp_dp;

  logic                div_last;
  logic                slot_last;
  logic                frame_last;
  logic [NDIG-1:0]     blank;
  logic [3:0]          nib;
  logic                cur_dp;
  logic                pwm_on;
  logic [NDIG-1:0]     onehot;
  logic [7:0]          nleds;
  logic [NDIG-1:0]     nct;

  function automatic logic [7:0] font(input logic [3:0] n);
    logic [7:0] s;
    unique case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      4'hF: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign div_last   = (div == DW'(SCAN_DIV - 1));
  assign slot_last  = div_last && (&step);
  assign frame_last = slot_last && (idx == IW'(NDIG - 1));

  // A digit blanks when it and every more significant nibble are zero.
  always_comb begin
    logic z;
    z     = 1'b1;
    blank = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      z        = z && (disp_val[4*i +: 4] == 4'h0);
      blank[i] = blank_lz && z && (i > 0);
    end
  end

  assign nib    = disp_val[4*idx +: 4];
  assign cur_dp = disp_dp[idx];
  assign pwm_on = (step < bright);
  assign onehot = NDIG'(1) << idx;

  always_comb begin
    nleds = {~cur_dp, font(nib)[6:0]};
    nct   = pwm_on ? onehot : '0;
    if (blank[idx]) begin
      nleds = cur_dp ? 8'h7F : 8'hFF;
      if (!cur_dp) nct = '0;
    end
`ifdef SEG_SCAN_LAMPTEST_EN
    if (lamp_test) begin
      nleds = 8'h00;
      nct   = pwm_on ? onehot : '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div        <= '0;
      step       <= '0;
      idx        <= '0;
      stage_val  <= '0;
      stage_dp   <= '0;
      pend       <= 1'b0;
      disp_val   <= '0;
      disp_dp    <= '0;
      leds       <= 8'hFF;
      ct         <= '0;
      frame_done <= 1'b0;
    end else begin
      div <= div_last ? '0 : div + DW'(1);
      if (div_last) step <= step + BRIGHT_W'(1);
      if (slot_last) idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
      frame_done <= frame_last;
      leds       <= nleds;
      ct         <= nct;
      if (load) begin
        stage_val <= value;
        stage_dp  <= dp;
        pend      <= 1'b1;
      end
      // A load on the boundary clock bypasses staging straight to display.
      if (frame_last) begin
        if (load) begin
          disp_val <= value;
          disp_dp  <= dp;
          pend     <= 1'b0;
        end else if (pend) begin
          disp_val <= stage_val;
          disp_dp  <= stage_dp;
          pend     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan with NDIG=4, SCAN_DIV=2, BRIGHT_W=2 (32-clock frames).
module tb_seg_scan;

  localparam int NDIG = 4;
  localparam int SDIV = 2;
  localparam int BW   = 2;
  localparam int L    = SDIV * (1 << BW);
  localparam int FR   = NDIG * L;

  logic            clk = 1'b0;
  logic            reset;
  logic [15:0]     value;
  logic [3:0]      dp;
  logic            load;
  logic [BW-1:0]   bright;
  logic            blank_lz;
  logic            lamp;
  logic [7:0]      leds;
  logic [3:0]      ct;
  logic            frame_done;

  seg_scan #(.NDIG(NDIG), .SCAN_DIV(SDIV), .BRIGHT_W(BW)) dut (
    .clk(clk),
    .reset(reset),
    .value(value),
    .dp(dp),
    .load(load),
    .bright(bright),
    .blank_lz(blank_lz),
`ifdef SEG_SCAN_LAMPTEST_EN
    .lamp_test(lamp),
`endif
    .leds(leds),
    .ct(ct),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] leds;
    logic [3:0] ct;
    logic       fd;
    logic       skip;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  logic [7:0] fnt [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int         pos;
  logic [15:0] m_disp, m_stage;
  logic [3:0]  m_ddp, m_sdp;
  logic        m_pend;

  logic [7:0] o_leds;
  logic [3:0] o_ct;
  logic       o_fd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    exp_t e;
    int d, st;
    logic blk;
    e = '{leds: 8'hFF, ct: 4'h0, fd: 1'b0, skip: 1'b0};
    if (!reset) begin
      d   = pos / L;
      st  = (pos % L) / SDIV;
      blk = blank_lz && d > 0 && ((m_disp >> (4 * d)) == 16'h0);
      e.ct   = (st < int'(bright)) ? 4'(1 << d) : 4'h0;
      e.leds = {~m_ddp[d], fnt[m_disp[4*d +: 4]][6:0]};
      e.fd   = (pos == FR - 1);
      if (blk && m_ddp[d]) e.leds = 8'h7F;
      else if (blk) begin
        e.ct   = 4'h0;
        e.skip = 1'b1;
      end
      if (lamp) begin
        e.leds = 8'h00;
        e.skip = 1'b0;
        e.ct   = (st < int'(bright)) ? 4'(1 << d) : 4'h0;
      end
    end
    q.push_back(e);
    @(posedge clk);
    if (reset) begin
      pos = 0; m_disp = 0; m_ddp = 0; m_stage = 0; m_sdp = 0; m_pend = 0;
    end else begin
      if (load) begin
        m_stage = value; m_sdp = dp; m_pend = 1;
      end
      if (pos == FR - 1) begin
        if (load) begin
          m_disp = value; m_ddp = dp; m_pend = 0;
        end else if (m_pend) begin
          m_disp = m_stage; m_ddp = m_sdp; m_pend = 0;
        end
      end
      pos = (pos + 1) % FR;
    end
    #1;
    e = q.pop_front();
    o_leds = leds; o_ct = ct; o_fd = frame_done;
    if (!e.skip) chk("leds", 32'(leds), 32'(e.leds));
    chk("ct", 32'(ct), 32'(e.ct));
    chk("frame_done", 32'(frame_done), 32'(e.fd));
  endtask

  task automatic wait_fd();
    bit seen;
    seen = 0;
    for (int i = 0; i < 2 * FR && !seen; i++) begin
      tick();
      if (o_fd) seen = 1;
    end
    if (!seen) chk("wait_fd_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int n, m, k;
    reset = 1'b1; value = 0; dp = 0; load = 0; bright = 3;
    blank_lz = 0; lamp = 0;
    pos = 0; m_disp = 0; m_ddp = 0; m_stage = 0; m_sdp = 0; m_pend = 0;
    tick(); tick();
    chk("rst_ct", 32'(o_ct), 32'h0);
    chk("rst_leds", 32'(o_leds), 32'hFF);
    chk("rst_fd", 32'(o_fd), 32'h0);
    reset = 1'b0;

    do_load(16'h1234);
    wait_fd();
    n = 0;
    for (int i = 0; i < L; i++) begin
      tick();
      if (o_ct == 4'b0001 && o_leds == 8'h99) n++;
    end
    chk("d0_duty_99", 32'(n), 32'd6);
    n = 0;
    for (int i = 0; i < FR - L; i++) begin
      tick();
      if (o_ct == 4'b1000 && o_leds == 8'hF9) n++;
    end
    chk("d3_F9", 32'(n), 32'd6);

    blank_lz = 1'b1;
    do_load(16'h0045);
    wait_fd();
    n = 0; m = 0; k = 0;
    for (int i = 0; i < FR; i++) begin
      tick();
      if (o_ct[3:2] != 2'b00) n++;
      if (o_ct == 4'b0010 && o_leds == 8'h99) m++;
      if (o_ct == 4'b0001 && o_leds == 8'h92) k++;
    end
    chk("blank_hi", 32'(n), 32'd0);
    chk("d1_99", 32'(m), 32'd6);
    chk("d0_92", 32'(k), 32'd6);

    dp = 4'b0100;
    do_load(16'h0000);
    wait_fd();
    n = 0; m = 0; k = 0;
    for (int i = 0; i < FR; i++) begin
      tick();
      if (o_ct[3] || o_ct[1]) n++;
      if (o_ct == 4'b0001 && o_leds == 8'hC0) m++;
      if (o_ct == 4'b0100 && o_leds == 8'h7F) k++;
    end
    chk("zero_only_d0", 32'(n), 32'd0);
    chk("zero_C0", 32'(m), 32'd6);
    chk("blank_dp_7F", 32'(k), 32'd6);
    dp = 4'b0000;
    do_load(16'h0000);

    bright = 0;
    wait_fd();
    n = 0; m = 0;
    for (int i = 0; i < 2 * FR; i++) begin
      tick();
      if (o_ct != 4'h0) n++;
      if (o_fd) m++;
    end
    chk("dark_ct", 32'(n), 32'd0);
    chk("dark_fd_count", 32'(m), 32'd2);

    bright = 3; blank_lz = 1'b0;
    wait_fd();
    for (int i = 0; i < 10; i++) tick();
    do_load(16'h1111);
    for (int i = 11; i < 20; i++) tick();
    do_load(16'h2222);
    n = 0;
    for (int i = 21; i < FR; i++) begin
      tick();
      if (o_leds == 8'hA4 || o_leds == 8'hF9) n++;
    end
    chk("no_midframe_change", 32'(n), 32'd0);
    chk("frame_boundary", 32'(o_fd), 32'd1);
    n = 0; m = 0;
    for (int i = 0; i < FR; i++) begin
      tick();
      if (o_ct != 4'h0 && o_leds == 8'hA4) n++;
      if (o_leds == 8'hF9) m++;
    end
    chk("all_A4", 32'(n), 32'd24);
    chk("never_1111", 32'(m), 32'd0);

    wait_fd();
    for (int i = 0; i < 13; i++) tick();
    reset = 1'b1;
    tick();
    chk("midrst_ct", 32'(o_ct), 32'h0);
    chk("midrst_leds", 32'(o_leds), 32'hFF);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < FR + 8; i++) begin
      tick();
      n++;
      if (o_fd) break;
    end
    chk("rst_fd_latency", 32'(n), 32'(FR));

`ifdef SEG_SCAN_LAMPTEST_EN
    lamp = 1'b1; blank_lz = 1'b1;
    wait_fd();
    n = 0; m = 0;
    for (int i = 0; i < FR; i++) begin
      tick();
      if (o_leds != 8'h00) n++;
      if ($onehot(o_ct)) m++;
    end
    chk("lamp_leds", 32'(n), 32'd0);
    chk("lamp_ct", 32'(m), 32'd24);
    lamp = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
